// File: rtl/cuadrado.sv
// Sequential shift-add squarer: Resultado = Op_A * Op_A.
// INIT/DONE start-complete handshake shared with the other arithmetic cores.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for INIT; Resultado holds the last square
// S_CHECK| inspect the multiplier LSB to choose add or shift
// S_ADD  | accumulate the shifted multiplicand into P
// S_SHIFT| shift A left, B right, decrement the bit counter
// S_END  | one-cycle DONE pulse, then back to idle
module cuadrado #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               INIT,
  input  logic [WIDTH-1:0]   Op_A,
  output logic               DONE,
  output logic               BUSY,
  output logic [2*WIDTH-1:0] Resultado
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [CW-1:0]      count;

  // Next-state decode; only IDLE looks at INIT, so requests while busy are dropped.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (INIT) state_next = S_CHECK;
      S_CHECK: state_next = b_reg[0] ? S_ADD : S_SHIFT;
      S_ADD:   state_next = S_SHIFT;
      S_SHIFT: state_next = (count == CW'(1)) ? S_END : S_CHECK;
      S_END:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus registered DONE/BUSY so the outputs never glitch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_next;
      DONE  <= (state_next == S_END);
      BUSY  <= (state_next != S_IDLE);
    end
  end

  // Datapath: operand capture on acceptance, accumulate in ADD, shift in SHIFT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (INIT) begin
            a_reg <= {{WIDTH{1'b0}}, Op_A};
            b_reg <= Op_A;
            p_reg <= '0;
            count <= CW'(WIDTH);
          end
        end
        S_ADD: begin
          p_reg <= p_reg + a_reg;
        end
        S_SHIFT: begin
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          count <= count - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign Resultado = p_reg;

endmodule

// File: doc/cuadrado.md
Name: cuadrado

Overview:
- Sequential shift-add squarer for the calculator datapath. It computes Resultado = Op_A × Op_A, the inverse operation of the square-root core.
- Used by the control unit to check a root, Resultado(root)² ≤ operand, and to serve the x² key.
- Uses the same INIT/DONE start-complete handshake as the other arithmetic cores, so it drops into the same operation multiplexer.

Parameters:
- WIDTH, 16, operand width in bits. Result width is 2*WIDTH.

Ports:
- CLK, input, 1, system clock; all state updates on the rising edge.
- RST_N, input, 1, asynchronous active-low reset.
- INIT, input, 1, start request; sampled only in IDLE.
- Op_A, input, WIDTH, operand; captured on the accepting edge.
- DONE, output, 1, one-cycle completion pulse; Resultado is valid while DONE is high.
- BUSY, output, 1, high from acceptance until DONE inclusive.
- Resultado, output, 2*WIDTH, square of the captured operand; holds until the next accepted INIT.

Behaviour:
- Reset (RST_N=0, async): state=IDLE, A=0, B=0, P=0, count=0, DONE=0, BUSY=0, Resultado=0. Takes effect immediately, including mid-operation. The first start after reset release needs a new INIT sampled high.
- Registers:
  - A: 2*WIDTH multiplicand, shifts left.
  - B: WIDTH multiplier, shifts right.
  - P: 2*WIDTH accumulator; Resultado = P.
  - count: ceil(log2(WIDTH+1)) bits.
- FSM states: IDLE, CHECK, ADD, SHIFT, END.
- IDLE:
  - BUSY=0.
  - If INIT=1 at an edge: A←zero-extended Op_A, B←Op_A, P←0, count←WIDTH, go to CHECK.
  - Otherwise stay; P (Resultado) is held.
- CHECK: if B[0]=1 go to ADD, else go to SHIFT. No register change.
- ADD: P←P+A, modulo 2^(2*WIDTH), then go to SHIFT. Overflow cannot occur for valid operands.
- SHIFT:
  - A←A<<1, B←B>>1, count←count−1.
  - If count−1=0 go to END, else go to CHECK.
- END: DONE=1 and BUSY=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: counting the accepting edge as edge 0, DONE is high in the cycle after edge 2*WIDTH + popcount(Op_A).
  - WIDTH=16: 32 cycles for Op_A=0, 48 cycles for Op_A=0xFFFF.
- INIT while BUSY: ignored; Op_A changes while BUSY have no effect.
- INIT held high continuously: END→IDLE, then a new operation starts on the next edge. Back-to-back throughput is one result per 2*WIDTH+pop+2 cycles.
- DONE and BUSY are registered state decodes, glitch-free. DONE is never high in two consecutive cycles.
- Resultado changes only in ADD and on the accepting edge (cleared to 0). Consumers must sample it on DONE.

Test Plan:
- Reset then Op_A=0, INIT one cycle → DONE pulse 32 cycles after acceptance; Resultado=0x00000000; BUSY low afterward.
- Op_A=3 → Resultado=0x00000009; DONE after 34 cycles.
- Op_A=255 → Resultado=0x0000FE01; DONE after 40 cycles. Op_A=0xFFFF → Resultado=0xFFFE0001; DONE after 48 cycles.
- Start Op_A=0x1234; at cycle 10 pulse INIT with Op_A=0x0005 → ignored; Resultado=0x014B5A90 and exactly one DONE pulse.
- Start Op_A=0xFFFF; assert RST_N=0 at cycle 20 → DONE=0, BUSY=0, Resultado=0 immediately. After release, Op_A=2 with INIT → Resultado=0x00000004.
- INIT held high with Op_A=7 → DONE pulses repeat every 37 cycles, each with Resultado=0x00000031; never two consecutive DONE cycles.
